// File: rtl/sd_uart_pkg.sv
// Shared definitions for the SD sector read-back / UART dump path:
// controller state encoding, sector geometry and UART frame timing.
package sd_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_BUSY,
        ST_FILL,
        ST_DRAIN,
        ST_NEXT,
        ST_DONE
    } dump_state_t;

    localparam int WORDS_PER_SECTOR = 256;
    localparam int UART_FRAME_BITS  = 10;

    function automatic int bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte transmitter with start/busy handshake; tx idles high and
// each bit is held for exactly BIT_CYCLES clocks.
module uart_byte_tx
    import sd_uart_pkg::*;
#(
    parameter int BIT_CYCLES = 5208
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx
);
    localparam int CNT_W = $clog2(BIT_CYCLES + 1);
    localparam int BIT_W = $clog2(UART_FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_FRAME_BITS - 1);

    logic [UART_FRAME_BITS-1:0] shift_q;
    logic [CNT_W-1:0]           baud_cnt_q;
    logic [BIT_W-1:0]           bit_cnt_q;
    logic                       busy_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            busy_q     <= 1'b0;
            shift_q    <= '1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else if (!busy_q) begin
            if (tx_start) begin
                busy_q     <= 1'b1;
                shift_q    <= {1'b1, tx_data, 1'b0};
                baud_cnt_q <= '0;
                bit_cnt_q  <= '0;
            end
        end else if (baud_cnt_q == BAUD_LAST) begin
            // Ones shift in behind the stop bit, leaving the line idle high.
            baud_cnt_q <= '0;
            shift_q    <= {1'b1, shift_q[UART_FRAME_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
                busy_q <= 1'b0;
            end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
        end
    end

    assign tx      = shift_q[0];
    assign tx_busy = busy_q;

endmodule

// File: rtl/sd_sector_uart_dump.sv
// Reads sectors from the SD read controller one at a time into a 16-bit
// sector buffer, then streams each word high byte first over the UART.
module sd_sector_uart_dump #(
    parameter int CLK_FREQ         = 50_000_000,
    parameter int BAUD             = 9600,
    parameter int WORDS_PER_SECTOR = sd_uart_pkg::WORDS_PER_SECTOR,
    parameter int ADDR_W           = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_done,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_sector,
    input  logic [15:0]       sector_cnt,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_busy,
    input  logic              rd_data_en,
    input  logic [15:0]       rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import sd_uart_pkg::*;

    localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
    localparam int AW         = $clog2(WORDS_PER_SECTOR);
    localparam int PTR_W      = $clog2(WORDS_PER_SECTOR + 1);
    localparam logic [PTR_W-1:0] FULL = PTR_W'(WORDS_PER_SECTOR);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] sector_q;
    logic [15:0]       remaining_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, fill_cnt;
    logic              byte_sel_q, word_valid_q, err_q;
    logic              wr_accept, tx_start, tx_busy;
    logic [15:0]       word_q;
    logic [15:0]       mem [WORDS_PER_SECTOR];

    assign wr_accept = (state_q == ST_FILL) && rd_data_en && (wr_ptr_q != FULL);
    assign fill_cnt  = wr_ptr_q + PTR_W'(wr_accept);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        tx_start = 1'b0;
        case (state_q)
            ST_IDLE:      if (start && init_done) state_d = (sector_cnt != 16'd0) ? ST_REQ : ST_DONE;
            ST_REQ:       state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (rd_busy) state_d = ST_FILL;
            ST_FILL:      if (!rd_busy) state_d = ST_DRAIN;
            ST_DRAIN: begin
                // Leave only once the final frame has fully left the line.
                if (rd_ptr_q == wr_ptr_q) begin
                    if (!tx_busy) state_d = ST_NEXT;
                end else if (!tx_busy && word_valid_q) begin
                    tx_start = 1'b1;
                end
            end
            ST_NEXT:      state_d = (remaining_q == 16'd1) ? ST_DONE : ST_REQ;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            sector_q     <= '0;
            remaining_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            byte_sel_q   <= 1'b0;
            word_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_valid_q <= (state_q == ST_DRAIN) && !(tx_start && byte_sel_q);
            case (state_q)
                ST_IDLE: if (start && init_done) begin
                    sector_q    <= start_sector;
                    remaining_q <= sector_cnt;
                    err_q       <= 1'b0;
                end
                ST_FILL: begin
                    if (rd_data_en && !wr_accept) err_q <= 1'b1;
                    if (wr_accept) wr_ptr_q <= fill_cnt;
                    if (!rd_busy && fill_cnt < FULL) err_q <= 1'b1;
                end
                ST_DRAIN: if (tx_start) begin
                    byte_sel_q <= !byte_sel_q;
                    if (byte_sel_q) rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                ST_NEXT: begin
                    remaining_q <= remaining_q - 16'd1;
                    sector_q    <= sector_q + 1'b1;
                    wr_ptr_q    <= '0;
                    rd_ptr_q    <= '0;
                    byte_sel_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the sector buffer is not reset; it is always written before it is read.
    always_ff @(posedge sys_clk) begin
        if (wr_accept) mem[wr_ptr_q[AW-1:0]] <= rd_data;
        word_q <= mem[rd_ptr_q[AW-1:0]];
    end

    uart_byte_tx #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_uart_byte_tx (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .tx_start(tx_start),
        .tx_data (byte_sel_q ? word_q[7:0] : word_q[15:8]),
        .tx_busy (tx_busy),
        .tx      (tx)
    );

    assign rd_en   = (state_q == ST_REQ);
    assign rd_addr = sector_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;

endmodule

// File: tb/tb_sd_sector_uart_dump.sv
// Randomised bench: an SD read controller model feeds sectors and a UART
// monitor decodes frames, compared against the words the model sent.
module tb_sd_sector_uart_dump;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 5_000_000;
    localparam int WPS      = 16;
    localparam int ADDR_W   = 32;

    logic              sys_clk = 1'b0;
    logic              sys_rst, init_done, start;
    logic [ADDR_W-1:0] start_sector;
    logic [15:0]       sector_cnt;
    logic              rd_en, rd_busy, rd_data_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data;
    logic              tx, busy, done, err;

    int n_words   = WPS;
    int word_mode = 0;
    int cyc = 0, rd_en_count = 0, done_count = 0, tx_low_count = 0;
    int checks = 0, errors = 0;

    logic [7:0]        exp_q[$];
    logic [7:0]        frame_q[$];
    int                frame_t[$];
    bit                frame_ok[$];
    logic [ADDR_W-1:0] addr_q[$];

    sd_sector_uart_dump #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .WORDS_PER_SECTOR(WPS), .ADDR_W(ADDR_W)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_done(init_done), .start(start),
        .start_sector(start_sector), .sector_cnt(sector_cnt), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_busy(rd_busy), .rd_data_en(rd_data_en), .rd_data(rd_data), .tx(tx),
        .busy(busy), .done(done), .err(err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (rd_en === 1'b1) rd_en_count <= rd_en_count + 1;
        if (done === 1'b1) done_count <= done_count + 1;
        if (tx === 1'b0) tx_low_count <= tx_low_count + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SD read controller: answers each rd_en with a burst of n_words words.
    initial begin
        logic [15:0] w;
        bit merge;
        rd_busy = 1'b0;
        rd_data_en = 1'b0;
        rd_data = '0;
        forever begin
            @(negedge sys_clk);
            if (rd_en === 1'b1 && sys_rst === 1'b0) begin
                addr_q.push_back(rd_addr);
                repeat ($urandom_range(1, 3)) @(negedge sys_clk);
                rd_busy = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge sys_clk);
                merge = 1'($urandom_range(0, 1));
                for (int i = 0; i < n_words; i++) begin
                    w = (word_mode == 0) ? 16'(i) : 16'($urandom);
                    if (i < WPS) begin
                        exp_q.push_back(w[15:8]);
                        exp_q.push_back(w[7:0]);
                    end
                    rd_data = w;
                    rd_data_en = 1'b1;
                    if (merge && i == n_words - 1) rd_busy = 1'b0;
                    @(negedge sys_clk);
                    rd_data_en = 1'b0;
                    if ($urandom_range(0, 3) == 0) @(negedge sys_clk);
                end
                rd_busy = 1'b0;
            end
        end
    end

    // UART monitor: decodes 8N1 frames, checking start/stop timing at 10 cycles per bit.
    initial begin
        logic prev;
        logic [7:0] b;
        bit ok;
        int c0;
        prev = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (prev === 1'b1 && tx === 1'b0) begin
                c0 = cyc;
                ok = 1'b1;
                b = '0;
                for (int k = 1; k <= 99; k++) begin
                    @(negedge sys_clk);
                    if (k == 9 && tx !== 1'b0) ok = 1'b0;
                    if (k >= 15 && k <= 85 && (k % 10) == 5) b[k / 10 - 1] = tx;
                    if ((k == 90 || k == 99) && tx !== 1'b1) ok = 1'b0;
                end
                frame_q.push_back(b);
                frame_t.push_back(c0);
                frame_ok.push_back(ok);
            end
            prev = tx;
        end
    end

    task automatic run_dump(input logic [ADDR_W-1:0] sa, input logic [15:0] cnt, input int nw,
                            input int md, input logic exp_err, input bit inject);
        int f0, e0, a0, r0, d0, t, limit, nf, fpw, got_f, bad;
        bit injected;
        f0 = frame_q.size();
        e0 = exp_q.size();
        a0 = addr_q.size();
        r0 = rd_en_count;
        d0 = done_count;
        n_words = nw;
        word_mode = md;
        fpw = 2 * ((nw < WPS) ? nw : WPS);
        nf = int'(cnt) * fpw;
        limit = nf * 110 + 500;
        @(negedge sys_clk);
        start = 1'b1;
        start_sector = sa;
        sector_cnt = cnt;
        @(negedge sys_clk);
        start = 1'b0;
        start_sector = $urandom;
        sector_cnt = 16'($urandom);
        check("busy_on_accept", busy, 1);
        check("err_cleared", err, 0);
        t = 0;
        injected = 1'b0;
        while (done_count == d0 && t < limit) begin
            @(negedge sys_clk);
            t++;
            if (inject && !injected && frame_q.size() - f0 >= 5) begin
                start = 1'b1;
                start_sector = 32'h0000_1234;
                sector_cnt = 16'd3;
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("dump_completes", done_count != d0, 1);
        check("busy_after_done", busy, 0);
        repeat (5) @(negedge sys_clk);
        check("done_pulses", done_count - d0, 1);
        check("rd_en_pulses", rd_en_count - r0, cnt);
        check("rd_addr_count", addr_q.size() - a0, cnt);
        bad = 0;
        for (int i = 0; i < addr_q.size() - a0 && i < int'(cnt); i++)
            if (addr_q[a0 + i] !== sa + ADDR_W'(i)) bad++;
        check("rd_addr_seq", bad, 0);
        got_f = frame_q.size() - f0;
        check("frame_count", got_f, nf);
        bad = 0;
        for (int i = 0; i < got_f && i < exp_q.size() - e0; i++)
            if (frame_q[f0 + i] !== exp_q[e0 + i]) bad++;
        check("frame_bytes", bad, 0);
        bad = 0;
        for (int i = 0; i < got_f; i++) begin
            if (!frame_ok[f0 + i]) bad++;
            if (i > 0 && fpw > 0 && (i % fpw) != 0 &&
                (frame_t[f0 + i] - frame_t[f0 + i - 1] < 100 ||
                 frame_t[f0 + i] - frame_t[f0 + i - 1] > 102)) bad++;
        end
        check("frame_timing", bad, 0);
        check("err_flag", err, exp_err);
    endtask

    initial begin
        int d0, r0, l0, f0, t;
        sys_rst = 1'b1;
        init_done = 1'b1;
        start = 1'b0;
        start_sector = '0;
        sector_cnt = '0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        run_dump(32'h0000_0010, 16'd1, WPS, 0, 1'b0, 1'b0);
        run_dump(32'hFFFF_FFFF, 16'd2, WPS, 1, 1'b0, 1'b0);

        d0 = done_count; r0 = rd_en_count; l0 = tx_low_count;
        @(negedge sys_clk);
        start = 1'b1; start_sector = 32'h55; sector_cnt = 16'd0;
        @(negedge sys_clk);
        start = 1'b0;
        check("zero_cnt_done", done, 1);
        @(negedge sys_clk);
        check("zero_cnt_done_once", done, 0);
        check("zero_cnt_idle", busy, 0);
        repeat (20) @(negedge sys_clk);
        check("zero_cnt_no_rd_en", rd_en_count - r0, 0);
        check("zero_cnt_tx_idle", tx_low_count - l0, 0);
        check("zero_cnt_done_count", done_count - d0, 1);

        d0 = done_count; r0 = rd_en_count;
        init_done = 1'b0;
        @(negedge sys_clk);
        start = 1'b1; start_sector = 32'h77; sector_cnt = 16'd2;
        @(negedge sys_clk);
        start = 1'b0;
        check("no_init_busy", busy, 0);
        repeat (20) @(negedge sys_clk);
        check("no_init_rd_en", rd_en_count - r0, 0);
        check("no_init_done", done_count - d0, 0);
        init_done = 1'b1;

        run_dump(32'h0000_0100, 16'd1, WPS * 3 / 4, 1, 1'b1, 1'b0);
        run_dump(32'h0000_0200, 16'd1, WPS + 4, 1, 1'b1, 1'b0);
        check("err_sticky", err, 1);
        run_dump(32'h0000_0300, 16'd1, WPS, 1, 1'b0, 1'b0);

        f0 = frame_q.size();
        n_words = WPS;
        word_mode = 1;
        @(negedge sys_clk);
        start = 1'b1; start_sector = 32'h400; sector_cnt = 16'd1;
        @(negedge sys_clk);
        start = 1'b0;
        t = 0;
        while (frame_q.size() - f0 < 2 && t < 5000) begin @(negedge sys_clk); t++; end
        while (tx !== 1'b0 && t < 5000) begin @(negedge sys_clk); t++; end
        check("third_frame_seen", t < 5000, 1);
        repeat (20) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("midrst_tx", tx, 1);
        check("midrst_rd_en", rd_en, 0);
        check("midrst_busy", busy, 0);
        repeat (200) @(negedge sys_clk);
        run_dump(32'h0000_0500, 16'd1, WPS, 0, 1'b0, 1'b0);

        run_dump(32'h0000_0600, 16'd1, WPS, 1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_sector_uart_dump.md
Name: sd_sector_uart_dump

Overview:
Read-back path for the SD/UART card logger. Requests sectors from the SD read controller, buffers one 512-byte sector (256 x 16-bit words), then serialises it on the UART tx line. Processes one sector at a time, strictly fill-then-drain, so it can never overrun. Sits beside the SD write path and shares the SD read controller port, sd_clk domain sys_clk.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz
BAUD, 9600, UART bit rate; BIT_CYCLES = CLK_FREQ/BAUD (integer divide)
WORDS_PER_SECTOR, 256, 16-bit words per sector
ADDR_W, 32, sector address width

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  synchronous reset, active-high
init_done  in  1  SD card initialisation complete
start  in  1  one-cycle request to begin a dump
start_sector  in  ADDR_W  first sector address, sampled with start
sector_cnt  in  16  number of sectors, sampled with start
rd_en  out  1  one-cycle sector read request to the SD read controller
rd_addr  out  ADDR_W  sector address; valid while rd_en is high
rd_busy  in  1  SD read controller busy
rd_data_en  in  1  rd_data valid strobe
rd_data  in  16  read word, big-endian within the word
tx  out  1  UART serial out, 8N1, LSB first
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at end of dump
err  out  1  sticky word-count error; cleared on next accepted start

Behaviour:
- Reset values: rd_en=0, rd_addr=0, tx=1, busy=0, done=0, err=0. FSM goes to IDLE and pointers go to 0.
- Reset mid-operation takes effect at the next edge. Any byte in flight is truncated and tx returns high.
- FSM states: IDLE, REQ, WAIT_BUSY, FILL, DRAIN, NEXT, DONE.
- IDLE:
  - start && init_done && sector_cnt!=0: latch the address and count, clear err, go to REQ. busy=1 from the next cycle.
  - start && init_done && sector_cnt==0: go to DONE, with no rd_en.
  - start while init_done=0: ignored.
  - start in any non-IDLE state: ignored.
- REQ: rd_en=1 for exactly one cycle with rd_addr=current sector, then go to WAIT_BUSY. rd_en rises one cycle after start is accepted.
- WAIT_BUSY: hold until rd_busy=1, then go to FILL. There is no timeout.
- FILL:
  - Each rd_data_en cycle writes buf[wr_ptr] and increments wr_ptr (9-bit).
  - Writes when wr_ptr==WORDS_PER_SECTOR are dropped and set err.
  - rd_busy sampled low goes to DRAIN. If wr_ptr<WORDS_PER_SECTOR at that point, set err and drain only the received words.
  - rd_data_en and the rd_busy fall in the same cycle: the word is written first.
- DRAIN:
  - For rd_ptr=0..wr_ptr-1, send the high byte then the low byte through the byte transmitter (start/busy handshake).
  - Start bit begins at most 2 cycles after DRAIN entry. Gap between successive frames is at most 2 cycles.
  - Zero received words: go directly to NEXT.
- NEXT: decrement remaining and increment the sector address (wraps modulo 2^ADDR_W). Reset wr_ptr and rd_ptr. Go to REQ if remaining!=0, else DONE.
- DONE: done=1 for one cycle, busy=0 the following cycle, go to IDLE.
- UART frame:
  - Start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit lasts exactly BIT_CYCLES cycles, so a frame is 10*BIT_CYCLES cycles.
  - tx idles at 1.
- Buffer is single-port-write / single-port-read, 256x16, inferred RAM. A one-cycle read latency is allowed and is included in the 2-cycle budget.

Decomposition:
- Shared package sd_uart_pkg holds:
  - FSM state encoding
  - WORDS_PER_SECTOR, UART_FRAME_BITS=10
  - a BIT_CYCLES helper function
- One sub-module, uart_byte_tx. Ports: sys_clk, sys_rst, tx_start, tx_data[7:0], tx_busy, tx. It contains the baud counter and bit counter.
- The FSM, buffer and pointers live in the top block.

Test Plan:
All scenarios use CLK_FREQ=50_000_000 and BAUD=5_000_000, giving BIT_CYCLES=10.
- Single sector: start with start_sector=0x10 and sector_cnt=1; model returns words 0x0000..0x00FF. Required: rd_en pulses once with rd_addr=0x10, tx emits 512 frames 00 00 00 01 ... 00 FF with each frame exactly 100 cycles, then done pulses once and err=0.
- Multi-sector with wrap: start_sector=0xFFFFFFFF and sector_cnt=2. Required: rd_addr sequence 0xFFFFFFFF then 0x00000000, 1024 frames, one done pulse.
- Boundary counts:
  - sector_cnt=0: done pulses 1 cycle after start, no rd_en, tx stays 1.
  - start with init_done=0: no response at all.
- Short and long sectors:
  - Model gives 200 words: err=1 and 400 frames are sent.
  - Model gives 260 words: err=1 and exactly 512 frames are sent.
  - err clears on the next accepted start.
- Reset mid-frame: assert sys_rst for 1 cycle during the 3rd frame. Required: next cycle tx=1, rd_en=0, busy=0. A fresh start then works normally.
- Start while busy: a second start pulse during DRAIN is ignored; rd_addr and the frame stream are unaffected.
